// File: rtl/ysyx_22041752_dsram.sv
// rtl/ysyx_22041752_dsram.sv - single-port byte-strobed data SRAM window with error and access counters
module ysyx_22041752_dsram #(
  parameter int                 ADDR_WD    = 64,
  parameter int                 DATA_WD    = 64,
  parameter int                 WEN_WD     = 8,
  parameter int                 DEPTH_LOG2 = 12,
  parameter logic [ADDR_WD-1:0] BASE       = 64'h8000_0000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic [WEN_WD-1:0]  wen,
  input  logic [ADDR_WD-1:0] addr,
  input  logic [DATA_WD-1:0] wdata,
  output logic [DATA_WD-1:0] rdata,
  output logic               rdat_v,
  output logic               err_o,
  output logic [7:0]         err_cnt,
  output logic [31:0]        rd_cnt,
  output logic [31:0]        wr_cnt
);

  localparam int TAG_LO = DEPTH_LOG2 + 3;

  logic [DATA_WD-1:0]    mem [2**DEPTH_LOG2];
  logic [DEPTH_LOG2-1:0] idx;
  logic                  hit;
  logic                  miss;
  logic                  wr_hit;
  logic                  rd_hit;
  logic                  unused_addr_lsb;

  // Byte offset within a word is carried by the strobes, not the address.
  assign unused_addr_lsb = ^addr[2:0];

  assign idx    = addr[DEPTH_LOG2+2:3];
  assign hit    = en && (addr[ADDR_WD-1:TAG_LO] == BASE[ADDR_WD-1:TAG_LO]);
  assign miss   = en && !hit;
  assign wr_hit = hit && (|wen);
  assign rd_hit = hit && !(|wen);

  // Array writes share the reset-qualified block so accesses during reset are dropped
  // while the contents themselves are never cleared.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdata   <= '0;
      rdat_v  <= 1'b0;
      err_o   <= 1'b0;
      err_cnt <= 8'd0;
      rd_cnt  <= 32'd0;
      wr_cnt  <= 32'd0;
    end else begin
      rdat_v <= rd_hit;
      if (rd_hit) begin
        rdata  <= mem[idx];
        rd_cnt <= rd_cnt + 32'd1;
      end
      if (wr_hit) begin
        wr_cnt <= wr_cnt + 32'd1;
        for (int b = 0; b < WEN_WD; b++) begin
          if (wen[b]) mem[idx][b*8 +: 8] <= wdata[b*8 +: 8];
        end
      end
      if (miss) begin
        err_o <= 1'b1;
        if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_ysyx_22041752_dsram.sv
// tb/tb_ysyx_22041752_dsram.sv - directed self-checking bench for ysyx_22041752_dsram
module tb_ysyx_22041752_dsram;

  logic        clk;
  logic        reset;
  logic        en;
  logic [7:0]  wen;
  logic [63:0] addr;
  logic [63:0] wdata;
  logic [63:0] rdata;
  logic        rdat_v;
  logic        err_o;
  logic [7:0]  err_cnt;
  logic [31:0] rd_cnt;
  logic [31:0] wr_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  ysyx_22041752_dsram dut (
    .clk    (clk),
    .reset  (reset),
    .en     (en),
    .wen    (wen),
    .addr   (addr),
    .wdata  (wdata),
    .rdata  (rdata),
    .rdat_v (rdat_v),
    .err_o  (err_o),
    .err_cnt(err_cnt),
    .rd_cnt (rd_cnt),
    .wr_cnt (wr_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Present one access for a single edge, then settle just past that edge.
  task automatic access(input logic e, input logic [7:0] w, input logic [63:0] a, input logic [63:0] d);
    en = e; wen = w; addr = a; wdata = d;
    @(posedge clk);
    #1;
    en = 1'b0; wen = 8'h00;
  endtask

  task automatic test_reset();
    reset = 1'b1; en = 1'b0; wen = 8'h00; addr = '0; wdata = '0;
    #1 reset = 1'b0;
    #2;
    n_cmp++; if (rdata !== 64'd0) begin n_bad++; $display("FAIL reset_rdata: got %h expected %h", rdata, 64'd0); end
    n_cmp++; if (rdat_v !== 1'b0) begin n_bad++; $display("FAIL reset_rdat_v: got %b expected 0", rdat_v); end
    n_cmp++; if (err_o !== 1'b0) begin n_bad++; $display("FAIL reset_err_o: got %b expected 0", err_o); end
    n_cmp++; if (err_cnt !== 8'd0) begin n_bad++; $display("FAIL reset_err_cnt: got %h expected 00", err_cnt); end
    n_cmp++; if (rd_cnt !== 32'd0 || wr_cnt !== 32'd0) begin n_bad++; $display("FAIL reset_counters: got rd %h wr %h expected 0 0", rd_cnt, wr_cnt); end
    @(posedge clk); @(posedge clk); #3;
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_write_read();
    access(1'b1, 8'hFF, 64'h8000_0010, 64'h1122334455667788);
    n_cmp++; if (rdat_v !== 1'b0) begin n_bad++; $display("FAIL wr_rdat_v: got %b expected 0", rdat_v); end
    access(1'b1, 8'h00, 64'h8000_0010, 64'h0);
    n_cmp++; if (rdat_v !== 1'b1) begin n_bad++; $display("FAIL rd_rdat_v: got %b expected 1", rdat_v); end
    n_cmp++; if (rdata !== 64'h1122334455667788) begin n_bad++; $display("FAIL rd_data: got %h expected %h", rdata, 64'h1122334455667788); end
    n_cmp++; if (wr_cnt !== 32'd1 || rd_cnt !== 32'd1) begin n_bad++; $display("FAIL rd_counters: got wr %0d rd %0d expected 1 1", wr_cnt, rd_cnt); end
  endtask

  task automatic test_partial();
    access(1'b1, 8'h0F, 64'h8000_0010, 64'hAAAAAAAA_BBBBBBBB);
    access(1'b1, 8'h00, 64'h8000_0010, 64'h0);
    n_cmp++; if (rdata !== 64'h11223344_BBBBBBBB || rdat_v !== 1'b1) begin n_bad++; $display("FAIL partial: got %h v=%b expected %h v=1", rdata, rdat_v, 64'h11223344_BBBBBBBB); end
    n_cmp++; if (wr_cnt !== 32'd2 || rd_cnt !== 32'd2) begin n_bad++; $display("FAIL partial_counters: got wr %0d rd %0d expected 2 2", wr_cnt, rd_cnt); end
  endtask

  task automatic test_miss();
    logic [63:0] prev;
    prev = rdata;
    access(1'b1, 8'h00, 64'h9000_0000, 64'h0);
    n_cmp++; if (rdat_v !== 1'b0) begin n_bad++; $display("FAIL miss_rdat_v: got %b expected 0", rdat_v); end
    n_cmp++; if (rdata !== prev) begin n_bad++; $display("FAIL miss_rdata_held: got %h expected %h", rdata, prev); end
    n_cmp++; if (err_o !== 1'b1 || err_cnt !== 8'd1) begin n_bad++; $display("FAIL miss_err: got err_o %b cnt %h expected 1 01", err_o, err_cnt); end
    n_cmp++; if (rd_cnt !== 32'd2) begin n_bad++; $display("FAIL miss_rd_cnt: got %0d expected 2", rd_cnt); end
    // A missed write whose low bits alias idx 2 must not touch the array.
    access(1'b1, 8'hFF, 64'h9000_0010, 64'hDEADBEEF_DEADBEEF);
    n_cmp++; if (wr_cnt !== 32'd2) begin n_bad++; $display("FAIL miss_wr_cnt: got %0d expected 2", wr_cnt); end
    access(1'b1, 8'h00, 64'h8000_0010, 64'h0);
    n_cmp++; if (rdata !== 64'h11223344_BBBBBBBB) begin n_bad++; $display("FAIL miss_mem_unchanged: got %h expected %h", rdata, 64'h11223344_BBBBBBBB); end
    for (int i = 0; i < 252; i++) access(1'b1, 8'h00, 64'h0000_1000 + 64'(i * 8), 64'h0);
    n_cmp++; if (err_cnt !== 8'hFE) begin n_bad++; $display("FAIL err_cnt_254: got %h expected fe", err_cnt); end
    access(1'b1, 8'h00, 64'h9000_0000, 64'h0);
    n_cmp++; if (err_cnt !== 8'hFF) begin n_bad++; $display("FAIL err_cnt_255: got %h expected ff", err_cnt); end
    for (int i = 0; i < 45; i++) access(1'b1, 8'h00, 64'hFFFF_0000_8000_0000, 64'h0);
    n_cmp++; if (err_cnt !== 8'hFF || err_o !== 1'b1) begin n_bad++; $display("FAIL err_cnt_sat: got %h err_o %b expected ff 1", err_cnt, err_o); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) access(1'b1, 8'hFF, 64'h8000_0000 + 64'(i * 8), 64'(i));
    for (int i = 0; i < 4; i++) begin
      access(1'b1, 8'h00, 64'h8000_0000 + 64'(i * 8), 64'h0);
      n_cmp++; if (rdat_v !== 1'b1 || rdata !== 64'(i)) begin n_bad++; $display("FAIL stream_%0d: got %h v=%b expected %h v=1", i, rdata, rdat_v, 64'(i)); end
    end
    access(1'b0, 8'h00, 64'h0, 64'h0);
    n_cmp++; if (rdat_v !== 1'b0 || rdata !== 64'd3) begin n_bad++; $display("FAIL stream_hold: got %h v=%b expected 3 v=0", rdata, rdat_v); end
  endtask

  task automatic test_idle();
    logic [31:0] rd0, wr0;
    logic [7:0]  e0;
    rd0 = rd_cnt; wr0 = wr_cnt; e0 = err_cnt;
    for (int i = 0; i < 10; i++) begin
      access(1'b0, 8'hFF, 64'h8000_0000 | 64'($urandom_range(0, 7) * 8), {$urandom, $urandom});
      en = 1'b0; wen = 8'hFF;
      n_cmp++; if (rdat_v !== 1'b0) begin n_bad++; $display("FAIL idle_rdat_v_%0d: got %b expected 0", i, rdat_v); end
    end
    wen = 8'h00;
    n_cmp++; if (rd_cnt !== rd0 || wr_cnt !== wr0 || err_cnt !== e0) begin n_bad++; $display("FAIL idle_counters: got rd %0d wr %0d err %0d expected %0d %0d %0d", rd_cnt, wr_cnt, err_cnt, rd0, wr0, e0); end
    for (int i = 0; i < 4; i++) begin
      access(1'b1, 8'h00, 64'h8000_0000 + 64'(i * 8), 64'h0);
      n_cmp++; if (rdata !== 64'(i)) begin n_bad++; $display("FAIL idle_mem_%0d: got %h expected %h", i, rdata, 64'(i)); end
    end
  endtask

  task automatic test_reset_mid();
    access(1'b1, 8'hFF, 64'h8000_0028, 64'h5555_0000_5555_0000);
    en = 1'b1; wen = 8'hFF; addr = 64'h8000_0028; wdata = 64'hCAFE_CAFE_CAFE_CAFE;
    #2 reset = 1'b0;
    #1;
    n_cmp++; if (rdata !== 64'd0 || rdat_v !== 1'b0 || err_o !== 1'b0 || err_cnt !== 8'd0 || rd_cnt !== 32'd0 || wr_cnt !== 32'd0) begin
      n_bad++; $display("FAIL midreset_outputs: got rdata %h v %b err %b ecnt %h rd %0d wr %0d expected all 0", rdata, rdat_v, err_o, err_cnt, rd_cnt, wr_cnt);
    end
    @(posedge clk); #1;
    en = 1'b0; wen = 8'h00;
    n_cmp++; if (wr_cnt !== 32'd0) begin n_bad++; $display("FAIL midreset_wr_cnt: got %0d expected 0", wr_cnt); end
    #2 reset = 1'b1;
    @(posedge clk); #1;
    access(1'b1, 8'h00, 64'h8000_0028, 64'h0);
    n_cmp++; if (rdata !== 64'h5555_0000_5555_0000 || rdat_v !== 1'b1) begin n_bad++; $display("FAIL midreset_idx5: got %h v=%b expected %h v=1", rdata, rdat_v, 64'h5555_0000_5555_0000); end
    access(1'b1, 8'h00, 64'h8000_0018, 64'h0);
    n_cmp++; if (rdata !== 64'd3) begin n_bad++; $display("FAIL midreset_idx3: got %h expected 3", rdata); end
    n_cmp++; if (rd_cnt !== 32'd2 || wr_cnt !== 32'd0) begin n_bad++; $display("FAIL midreset_counters: got rd %0d wr %0d expected 2 0", rd_cnt, wr_cnt); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_partial();
    test_miss();
    test_back_to_back();
    test_idle();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
